calc_seq_alu: RTL

//  Parametrised, handshaked successor of the 64-bit combinational calculator.

---
 rtl/calc_seq_alu.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_alu.sv
// Handshaked unsigned ALU: single-cycle add/sub, WIDTH-iteration shift-add multiply
// and restoring divide/remainder, with carry/borrow/overflow and error status flags.
module calc_seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             div_by_zero,
    output logic             bad_mode,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready, and a
    // result transfers on a rising edge where out_valid && out_ready. Neither side may be
    // withdrawn by the block once raised; result and flags stay stable while out_valid is high.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] M_ADD = 4'd0;
    localparam logic [3:0] M_SUB = 4'd1;
    localparam logic [3:0] M_MUL = 4'd2;
    localparam logic [3:0] M_DIV = 4'd3;
    localparam logic [3:0] M_REM = 4'd4;

    state_t             state_q, state_d;
    logic               init_q;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;
    logic               bad_q, bad_d;
    logic               is_mul_q, is_mul_d;
    logic               is_rem_q, is_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   shf_q, shf_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               quo_bit;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_next;

    // acc holds the product in multiply and the partial remainder in divide;
    // shf holds the multiplier bits or the dividend bits shifting into the quotient.
    always_comb begin : datapath
        add_full  = {1'b0, a} + {1'b0, b};
        sub_full  = {1'b0, a} - {1'b0, b};
        acc_step  = shf_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvsr_q};
        quo_bit   = ~rem_diff[WIDTH];
        quo_next  = {shf_q[WIDTH-2:0], quo_bit};
        rem_next  = quo_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        bad_d    = bad_q;
        is_mul_d = is_mul_q;
        is_rem_d = is_rem_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shf_d    = shf_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;

        in_ready  = init_q && (state_q == S_IDLE);
        accept    = in_valid && in_ready;
        last_iter = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    bad_d    = 1'b0;
                    cnt_d    = '0;
                    acc_d    = '0;
                    is_mul_d = (mode == M_MUL);
                    is_rem_d = (mode == M_REM);
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    shf_d    = (mode == M_MUL) ? b : a;
                    dvsr_d   = b;
                    state_d  = S_DONE;
                    case (mode)
                        M_ADD: begin
                            result_d = add_full[WIDTH-1:0];
                            ovf_d    = add_full[WIDTH];
                        end
                        M_SUB: begin
                            result_d = sub_full[WIDTH-1:0];
                            ovf_d    = sub_full[WIDTH];
                        end
                        M_MUL: state_d = S_CALC;
                        M_DIV, M_REM: begin
                            if (b == '0) begin
                                dbz_d    = 1'b1;
                                result_d = (mode == M_DIV) ? '1 : a;
                            end else begin
                                state_d = S_CALC;
                            end
                        end
                        default: bad_d = 1'b1;
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_mul_q) begin
                    acc_d   = acc_step;
                    mcand_d = mcand_q << 1;
                    shf_d   = shf_q >> 1;
                end else begin
                    acc_d = {{WIDTH{1'b0}}, rem_next};
                    shf_d = quo_next;
                end
                // Result is written only on the final iteration so nothing partial is visible.
                if (last_iter) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (is_mul_q) begin
                        result_d = acc_step[WIDTH-1:0];
                        ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    end else begin
                        result_d = is_rem_q ? rem_next : quo_next;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            bad_q    <= 1'b0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shf_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            bad_q    <= bad_d;
            is_mul_q <= is_mul_d;
            is_rem_q <= is_rem_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            shf_q    <= shf_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_q;
    assign bad_mode    = bad_q;
    assign dbg_state   = state_q;

endmodule
